// File: rtl/kf_lif_core_mc_if.sv
// Spike handshake bundle between the tile NoC router and the LIF core.
// master = router/bench side, slave = core side.
interface kf_lif_core_mc_if #(
    parameter int N_IN  = 2,
    parameter int NID_W = 8
);
    logic [N_IN-1:0]       spike_in_valid;
    logic [N_IN-1:0]       spike_in_ready;
    logic [N_IN*NID_W-1:0] spike_in_pre_id;
    logic [N_IN*8-1:0]     spike_in_payload;
    logic                  spike_out_valid;
    logic                  spike_out_ready;
    logic [NID_W-1:0]      spike_out_post_id;
    logic [7:0]            spike_out_payload;

    modport master (
        output spike_in_valid,
        output spike_in_pre_id,
        output spike_in_payload,
        input  spike_in_ready,
        input  spike_out_valid,
        input  spike_out_post_id,
        input  spike_out_payload,
        output spike_out_ready
    );

    modport slave (
        input  spike_in_valid,
        input  spike_in_pre_id,
        input  spike_in_payload,
        output spike_in_ready,
        output spike_out_valid,
        output spike_out_post_id,
        output spike_out_payload,
        input  spike_out_ready
    );
endinterface

// File: rtl/kf_lif_core_mc.sv
// Event-driven LIF tile core: round-robin spike intake, synapse walk,
// saturating integration, leak sweep, refractory and output FIFO.
module kf_lif_core_mc #(
    parameter int N_NEURONS  = 256,
    parameter int N_SYNAPSES = 4096,
    parameter int N_IN       = 2,
    parameter int V_WIDTH    = 16,
    parameter int W_WIDTH    = 8,
    parameter int REF_WIDTH  = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int NID_W     = $clog2(N_NEURONS),
    localparam int SID_W     = $clog2(N_SYNAPSES)
) (
    input  logic                       clk,
    input  logic                       rst,
    kf_lif_core_mc_if.slave            sif,
    input  logic                       leak_tick,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [SID_W-1:0]           cfg_addr,
    input  logic [31:0]                cfg_wdata,
    input  logic signed [V_WIDTH-1:0]  cfg_thresh,
    input  logic [3:0]                 cfg_leak_shift,
    input  logic [REF_WIDTH-1:0]       cfg_refrac,
    output logic [15:0]                drop_count,
    output logic                       core_busy
);
    localparam int RR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int FE_W = NID_W + 8;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_WALK,
        ST_ACC,
        ST_LEAK
    } state_t;

    state_t state, state_nx;

    logic [NID_W-1:0] cnt;
    logic             cnt_last;
    logic [RR_W-1:0]  rr_ptr;
    logic             leak_pending;
    logic [NID_W-1:0] pre_r;
    logic [7:0]       pay_r;
    logic [SID_W-1:0] idx_r;
    logic [SID_W-1:0] end_r;
    logic             first_r;

    logic [W_WIDTH+NID_W-1:0]  syn_mem [N_SYNAPSES];
    logic [2*SID_W-1:0]        idx_mem [N_NEURONS];
    logic signed [V_WIDTH-1:0] vmem    [N_NEURONS];
    logic [REF_WIDTH-1:0]      refm    [N_NEURONS];
    logic [W_WIDTH+NID_W-1:0]  syn_rd;
    logic [2*SID_W-1:0]        idx_rd;

    logic            gnt_found;
    logic [RR_W-1:0] gnt_idx;
    logic [NID_W-1:0] gnt_pre;
    logic [7:0]      gnt_pay;
    logic            can_accept;
    logic            accept;
    logic            cfg_ok;
    logic [NID_W-1:0] cfg_nid;
    logic            cfg_unused;

    logic [SID_W-1:0] cur_idx;
    logic [SID_W-1:0] cur_end;
    logic             walk_empty;

    logic [NID_W-1:0]          syn_post;
    logic signed [W_WIDTH-1:0] syn_w;
    logic signed [V_WIDTH-1:0] v_cur;
    logic [REF_WIDTH-1:0]      ref_cur;
    logic [V_WIDTH:0]          sum;
    logic signed [V_WIDTH-1:0] nv;
    logic                      skip;
    logic                      fire;

    logic signed [V_WIDTH-1:0] lv;
    logic signed [V_WIDTH-1:0] lnew;
    logic [REF_WIDTH-1:0]      lref;
    logic [REF_WIDTH-1:0]      lref_new;

    logic [FE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    assign cnt_last   = (cnt == NID_W'(N_NEURONS - 1));
    assign can_accept = (state == ST_IDLE) && !leak_pending;
    assign accept     = can_accept && gnt_found;
    assign cfg_ok     = cfg_we && (state == ST_IDLE) && !accept;
    assign cfg_nid    = cfg_addr[NID_W-1:0];
    assign cfg_unused = ^cfg_wdata[31:2*SID_W];
    assign core_busy  = (state != ST_IDLE);

    // First valid port at or after rr_ptr, wrapping.
    always_comb begin
        int p;
        p         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            p = (int'(rr_ptr) + k) % N_IN;
            if (!gnt_found && sif.spike_in_valid[p]) begin
                gnt_found = 1'b1;
                gnt_idx   = RR_W'(p);
            end
        end
    end

    always_comb begin
        gnt_pre = sif.spike_in_pre_id[int'(gnt_idx)*NID_W +: NID_W];
        gnt_pay = sif.spike_in_payload[int'(gnt_idx)*8 +: 8];
        sif.spike_in_ready = '0;
        if (accept) sif.spike_in_ready[gnt_idx] = 1'b1;
    end

    // The first WALK after LOAD takes the range straight from the index RAM.
    assign cur_idx    = first_r ? idx_rd[2*SID_W-1:SID_W] : idx_r;
    assign cur_end    = first_r ? idx_rd[SID_W-1:0] : end_r;
    assign walk_empty = (cur_idx > cur_end);

    assign syn_post = syn_rd[W_WIDTH +: NID_W];
    assign syn_w    = syn_rd[W_WIDTH-1:0];
    assign v_cur    = vmem[syn_post];
    assign ref_cur  = refm[syn_post];
    assign skip     = (ref_cur != '0);

    always_comb begin
        sum = {v_cur[V_WIDTH-1], v_cur}
            + {{(V_WIDTH + 1 - W_WIDTH){syn_w[W_WIDTH-1]}}, syn_w};
        nv = sum[V_WIDTH-1:0];
        if (sum[V_WIDTH] != sum[V_WIDTH-1]) begin
            nv = sum[V_WIDTH] ? {1'b1, {(V_WIDTH-1){1'b0}}}
                              : {1'b0, {(V_WIDTH-1){1'b1}}};
        end
    end

    assign fire = (state == ST_ACC) && !skip && (nv >= cfg_thresh);

    always_comb begin
        lv       = vmem[cnt];
        lref     = refm[cnt];
        lnew     = lv;
        lref_new = lref;
        if (cfg_leak_shift != 4'd0) lnew = lv - (lv >>> cfg_leak_shift);
        if (lref != '0) lref_new = lref - REF_WIDTH'(1);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT: if (cnt_last) state_nx = ST_IDLE;
            ST_IDLE: begin
                if (leak_pending)   state_nx = ST_LEAK;
                else if (gnt_found) state_nx = ST_LOAD;
            end
            ST_LOAD: state_nx = ST_WALK;
            ST_WALK: state_nx = walk_empty ? ST_IDLE : ST_ACC;
            ST_ACC:  state_nx = (idx_r == end_r) ? ST_IDLE : ST_WALK;
            ST_LEAK: if (cnt_last) state_nx = ST_IDLE;
            default: state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            cnt          <= '0;
            rr_ptr       <= '0;
            leak_pending <= 1'b0;
            pre_r        <= '0;
            pay_r        <= '0;
            idx_r        <= '0;
            end_r        <= '0;
            first_r      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT || state == ST_LEAK) begin
                cnt <= cnt_last ? '0 : cnt + NID_W'(1);
            end
            if (accept) begin
                pre_r  <= gnt_pre;
                pay_r  <= gnt_pay;
                rr_ptr <= (gnt_idx == RR_W'(N_IN - 1)) ? '0
                                                       : gnt_idx + RR_W'(1);
            end
            if (state == ST_LOAD) first_r <= 1'b1;
            if (state == ST_WALK) begin
                idx_r   <= cur_idx;
                end_r   <= cur_end;
                first_r <= 1'b0;
            end
            if (state == ST_ACC && idx_r != end_r) idx_r <= idx_r + SID_W'(1);
            // Ticks arriving during the sweep fold into it.
            if (state == ST_LEAK && cnt_last) leak_pending <= 1'b0;
            else if (leak_tick && state != ST_LEAK) leak_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        idx_rd <= idx_mem[pre_r];
        syn_rd <= syn_mem[cur_idx];
        if (cfg_ok && cfg_sel == 2'd0) begin
            syn_mem[cfg_addr] <= cfg_wdata[W_WIDTH+NID_W-1:0];
        end
        if (cfg_ok && cfg_sel == 2'd1) begin
            idx_mem[cfg_nid] <= cfg_wdata[2*SID_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            vmem[cnt] <= '0;
            refm[cnt] <= '0;
        end else if (state == ST_LEAK) begin
            vmem[cnt] <= lnew;
            refm[cnt] <= lref_new;
        end else if (state == ST_ACC && !skip) begin
            vmem[syn_post] <= fire ? '0 : nv;
            if (fire) refm[syn_post] <= cfg_refrac;
        end else if (cfg_ok && cfg_sel == 2'd2) begin
            vmem[cfg_nid] <= cfg_wdata[V_WIDTH-1:0];
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && sif.spike_out_ready;
    assign push  = fire && (!full || pop);
    assign drop  = fire && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= {syn_post, pay_r};
    end

    assign sif.spike_out_valid   = !empty;
    assign sif.spike_out_post_id = empty ? '0
                                 : fifo_mem[rd_ptr[AW-1:0]][8 +: NID_W];
    assign sif.spike_out_payload = empty ? '0
                                 : fifo_mem[rd_ptr[AW-1:0]][7:0];
endmodule
